// File: rtl/snek_game_ctrl.sv
// snek_game_ctrl: splash/play/death sequencing, direction capture, frame pacing and food/score bookkeeping.
// Optional: define SNEK_SPLASH_SKIP_EN to let any button press end the splash screen early.
module snek_game_ctrl #(
    parameter int unsigned GRID_W    = 32,
    parameter int unsigned GRID_H    = 24,
    parameter int unsigned COORD_W   = 6,
    parameter int unsigned LEN_W     = 8,
    parameter int unsigned TICK_BASE = 3125000,
    parameter int unsigned TICK_STEP = 200000,
    parameter int unsigned TICK_MIN  = 625000,
    parameter int unsigned MS_CYCLES = 12500,
    parameter int unsigned SPLASH_MS = 10000,
    parameter int unsigned DEAD_MS   = 2000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [3:0]         buttons_i,
    input  logic [COORD_W-1:0] head_h_i,
    input  logic [COORD_W-1:0] head_v_i,
    input  logic [COORD_W-1:0] food_h_i,
    input  logic [COORD_W-1:0] food_v_i,
    input  logic [LEN_W-1:0]   snek_len_i,
    input  logic               dead_i,
    output logic [1:0]         dir_o,
    output logic               frame_tick_o,
    output logic               grow_flag_o,
    output logic               new_food_flag_o,
    output logic               game_rst_o,
    output logic               run_o,
    output logic [1:0]         state_o,
    output logic [LEN_W-1:0]   score_o
);
    localparam int unsigned PW     = 32;
    localparam int unsigned MSP_W  = $clog2(MS_CYCLES + 1);
    localparam int unsigned MS_MAX = (SPLASH_MS > DEAD_MS) ? SPLASH_MS : DEAD_MS;
    localparam int unsigned MSC_W  = $clog2(MS_MAX + 1);

    localparam logic [1:0] ST_SPLASH  = 2'd0;
    localparam logic [1:0] ST_RESTART = 2'd1;
    localparam logic [1:0] ST_PLAY    = 2'd2;
    localparam logic [1:0] ST_DYING   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [MSP_W-1:0] ms_pre_q, ms_pre_d;
    logic [MSC_W-1:0] ms_cnt_q, ms_cnt_d;
    logic [PW-1:0]    frame_cnt_q, frame_cnt_d;
    logic [PW-1:0]    period_q, period_d;
    logic [1:0]       dir_q, dir_d;
    logic [1:0]       pending_q, pending_d;
    logic [LEN_W-1:0] score_q, score_d;
    logic             match_q;
    logic             frame_tick_q, frame_tick_d;
    logic             grow_q, grow_d;
    logic             new_food_q, new_food_d;
    logic             game_rst_q, game_rst_d;
    logic             run_q, run_d;

    logic             ms_tick;
    logic             match;
    logic             food_invalid;
    logic             splash_skip;
    logic             hit;
    logic [1:0]       cand_dir;
    logic [PW-1:0]    prod;
    logic [PW-1:0]    period_new;

    assign ms_tick      = (ms_pre_q == MSP_W'(MS_CYCLES - 1));
    assign match        = (head_h_i == food_h_i) && (head_v_i == food_v_i);
    assign food_invalid = (PW'(food_h_i) >= GRID_W) || (PW'(food_v_i) >= GRID_H);

`ifdef SNEK_SPLASH_SKIP_EN
    assign splash_skip = |buttons_i;
`else
    assign splash_skip = 1'b0;
`endif

    // Frame period shrinks with length but is clamped before it can drop under the floor.
    assign prod       = PW'(TICK_STEP) * PW'(snek_len_i);
    assign period_new = (prod >= PW'(TICK_BASE - TICK_MIN)) ? PW'(TICK_MIN)
                                                            : PW'(TICK_BASE) - prod;

    // Button priority: left > right > up > down.
    always_comb begin
        cand_dir = 2'd3;
        if (buttons_i[1])      cand_dir = 2'd0;
        else if (buttons_i[0]) cand_dir = 2'd1;
        else if (buttons_i[2]) cand_dir = 2'd2;
    end

    always_comb begin
        state_d      = state_q;
        ms_pre_d     = ms_tick ? '0 : ms_pre_q + MSP_W'(1);
        ms_cnt_d     = ms_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        period_d     = period_q;
        dir_d        = dir_q;
        pending_d    = pending_q;
        score_d      = score_q;
        frame_tick_d = 1'b0;
        hit          = 1'b0;

        case (state_q)
            ST_SPLASH: begin
                if (splash_skip) begin
                    state_d  = ST_RESTART;
                    ms_cnt_d = '0;
                end else if (ms_tick) begin
                    if (ms_cnt_q == MSC_W'(SPLASH_MS - 1)) begin
                        state_d  = ST_RESTART;
                        ms_cnt_d = '0;
                    end else begin
                        ms_cnt_d = ms_cnt_q + MSC_W'(1);
                    end
                end
            end
            ST_RESTART: state_d = ST_PLAY;
            ST_PLAY: begin
                // Death pre-empts both the frame tick and any food hit in the same cycle.
                if (dead_i) begin
                    state_d  = ST_DYING;
                    ms_cnt_d = '0;
                end else begin
                    if (frame_cnt_q >= period_q - PW'(1)) begin
                        frame_tick_d = 1'b1;
                        frame_cnt_d  = '0;
                        period_d     = period_new;
                    end else begin
                        frame_cnt_d = frame_cnt_q + PW'(1);
                    end
                    hit = match && !match_q;
                end
            end
            ST_DYING: begin
                if (ms_tick) begin
                    if (ms_cnt_q == MSC_W'(DEAD_MS - 1)) begin
                        state_d  = ST_RESTART;
                        ms_cnt_d = '0;
                    end else begin
                        ms_cnt_d = ms_cnt_q + MSC_W'(1);
                    end
                end
            end
        endcase

        // Reversal (left<->right, up<->down) is the low bit flipped.
        if (frame_tick_d && (pending_q != (dir_q ^ 2'd1))) dir_d = pending_q;
        if ((state_q != ST_SPLASH) && (|buttons_i)) pending_d = cand_dir;
        if (hit && (score_q != {LEN_W{1'b1}})) score_d = score_q + LEN_W'(1);

        if (state_d == ST_RESTART) begin
            score_d     = '0;
            dir_d       = 2'd0;
            frame_cnt_d = '0;
            period_d    = period_new;
        end

        grow_d     = hit;
        new_food_d = hit || food_invalid || (state_d == ST_RESTART);
        game_rst_d = (state_d == ST_RESTART);
        run_d      = (state_d == ST_PLAY);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_SPLASH;
            ms_pre_q     <= '0;
            ms_cnt_q     <= '0;
            frame_cnt_q  <= '0;
            period_q     <= PW'(TICK_BASE);
            dir_q        <= 2'd0;
            pending_q    <= 2'd0;
            score_q      <= '0;
            match_q      <= 1'b0;
            frame_tick_q <= 1'b0;
            grow_q       <= 1'b0;
            new_food_q   <= 1'b0;
            game_rst_q   <= 1'b0;
            run_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ms_pre_q     <= ms_pre_d;
            ms_cnt_q     <= ms_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            period_q     <= period_d;
            dir_q        <= dir_d;
            pending_q    <= pending_d;
            score_q      <= score_d;
            match_q      <= match;
            frame_tick_q <= frame_tick_d;
            grow_q       <= grow_d;
            new_food_q   <= new_food_d;
            game_rst_q   <= game_rst_d;
            run_q        <= run_d;
        end
    end

    assign state_o         = state_q;
    assign dir_o           = dir_q;
    assign score_o         = score_q;
    assign frame_tick_o    = frame_tick_q;
    assign grow_flag_o     = grow_q;
    assign new_food_flag_o = new_food_q;
    assign game_rst_o      = game_rst_q;
    assign run_o           = run_q;

endmodule

// File: tb/tb_snek_game_ctrl.sv
// tb_snek_game_ctrl: scoreboard bench for snek_game_ctrl; a behavioural model queues expected outputs per cycle.
module tb_snek_game_ctrl;
    localparam int GW = 32, GH = 24, CW = 6, LW = 8;
    localparam int TB = 100, TS = 10, TM = 30;
    localparam int MSC = 4, SMS = 3, DMS = 2;
    localparam int SCORE_MAX = (1 << LW) - 1;
`ifdef SNEK_SPLASH_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    buttons;
    logic [CW-1:0] head_h, head_v, food_h, food_v;
    logic [LW-1:0] snek_len;
    logic          dead;
    logic [1:0]    dir_o, state_o;
    logic          frame_tick_o, grow_flag_o, new_food_flag_o, game_rst_o, run_o;
    logic [LW-1:0] score_o;

    always #5 clk = ~clk;

    snek_game_ctrl #(
        .GRID_W(GW), .GRID_H(GH), .COORD_W(CW), .LEN_W(LW),
        .TICK_BASE(TB), .TICK_STEP(TS), .TICK_MIN(TM),
        .MS_CYCLES(MSC), .SPLASH_MS(SMS), .DEAD_MS(DMS)
    ) dut (
        .clk_i(clk), .rst_i(rst), .buttons_i(buttons),
        .head_h_i(head_h), .head_v_i(head_v), .food_h_i(food_h), .food_v_i(food_v),
        .snek_len_i(snek_len), .dead_i(dead),
        .dir_o(dir_o), .frame_tick_o(frame_tick_o), .grow_flag_o(grow_flag_o),
        .new_food_flag_o(new_food_flag_o), .game_rst_o(game_rst_o), .run_o(run_o),
        .state_o(state_o), .score_o(score_o)
    );

    typedef struct packed {
        logic [1:0]    st;
        logic [1:0]    dir;
        logic          run;
        logic          grst;
        logic          nf;
        logic          grow;
        logic          tick;
        logic [LW-1:0] score;
    } obs_t;

    obs_t exp_q[$];
    obs_t mon_e, mon_a;
    int   total = 0;
    int   bad   = 0;

    // Model state: game phase, millisecond timing, frame timing, steering and score.
    int m_state, m_pre, m_cnt, m_fcnt, m_per, m_dir, m_pend, m_score;
    bit m_prev;

    function automatic int period_of(int len);
        int prod;
        prod = TS * len;
        return (prod >= TB - TM) ? TM : TB - prod;
    endfunction

    task automatic model_step();
        obs_t e;
        bit   mt, match, inv, tick, hit;
        int   ns;
        if (rst) begin
            m_state = 0; m_pre = 0; m_cnt = 0; m_fcnt = 0; m_per = TB;
            m_dir = 0; m_pend = 0; m_score = 0; m_prev = 0;
            e = '0;
            exp_q.push_back(e);
            return;
        end
        tick  = 0;
        hit   = 0;
        ns    = m_state;
        mt    = (m_pre == MSC - 1);
        m_pre = mt ? 0 : m_pre + 1;
        match = (head_h == food_h) && (head_v == food_v);
        inv   = (int'(food_h) >= GW) || (int'(food_v) >= GH);
        case (m_state)
            0: begin
                if (SKIP && buttons != 4'd0) begin
                    ns = 1; m_cnt = 0;
                end else if (mt) begin
                    if (m_cnt + 1 == SMS) begin ns = 1; m_cnt = 0; end
                    else m_cnt++;
                end
            end
            1: ns = 2;
            2: begin
                if (dead) begin
                    ns = 3; m_cnt = 0;
                end else begin
                    m_fcnt++;
                    if (m_fcnt == m_per) begin
                        tick = 1; m_fcnt = 0; m_per = period_of(int'(snek_len));
                    end
                    hit = match && !m_prev;
                end
            end
            default: begin
                if (mt) begin
                    if (m_cnt + 1 == DMS) begin ns = 1; m_cnt = 0; end
                    else m_cnt++;
                end
            end
        endcase
        if (tick && !((m_pend / 2 == m_dir / 2) && (m_pend != m_dir))) m_dir = m_pend;
        if (m_state != 0 && buttons != 4'd0)
            m_pend = buttons[1] ? 0 : buttons[0] ? 1 : buttons[2] ? 2 : 3;
        if (hit && m_score < SCORE_MAX) m_score++;
        if (ns == 1) begin
            m_score = 0; m_dir = 0; m_fcnt = 0; m_per = period_of(int'(snek_len));
        end
        m_prev  = match;
        m_state = ns;
        e.st    = 2'(ns);
        e.dir   = 2'(m_dir);
        e.run   = (ns == 2);
        e.grst  = (ns == 1);
        e.nf    = (ns == 1) || hit || inv;
        e.grow  = hit;
        e.tick  = tick;
        e.score = LW'(m_score);
        exp_q.push_back(e);
    endtask

    // One clock: queue the expected post-edge outputs, then advance to the next falling edge.
    task automatic step();
        model_step();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic wait_tick(input string name);
        int n;
        n = 0;
        do begin step(); n++; end while (frame_tick_o !== 1'b1 && n < 400);
        if (frame_tick_o !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL %s: no frame_tick within %0d cycles", name, n);
        end
    endtask

    task automatic toggle_hit();
        food_h = 6'd10; food_v = 6'd10;
        step();
        food_h = 6'd5;  food_v = 6'd5;
        step();
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {state_o, dir_o, run_o, game_rst_o, new_food_flag_o, grow_flag_o, frame_tick_o, score_o};
            total++;
            if (mon_a !== mon_e) begin
                bad++;
                $display("FAIL outputs t=%0t got st=%0d dir=%0d run=%0b grst=%0b nf=%0b grow=%0b tick=%0b score=%0d expected st=%0d dir=%0d run=%0b grst=%0b nf=%0b grow=%0b tick=%0b score=%0d",
                         $time, mon_a.st, mon_a.dir, mon_a.run, mon_a.grst, mon_a.nf, mon_a.grow, mon_a.tick, mon_a.score,
                         mon_e.st, mon_e.dir, mon_e.run, mon_e.grst, mon_e.nf, mon_e.grow, mon_e.tick, mon_e.score);
            end
        end
    end

    initial begin
        int n, grows, nfs;
        int lens[4];
        int pers[4];
        lens = '{0, 5, 9, 200};
        pers = '{100, 50, 30, 30};
        rst = 1'b1; buttons = 4'd0; dead = 1'b0; snek_len = '0;
        head_h = 6'd5; head_v = 6'd5; food_h = 6'd10; food_v = 6'd10;
        @(negedge clk);
        step();
        rst = 1'b0;

        // Splash timeout: 3 ms of 4 cycles each.
        n = 0;
        do begin step(); n++; end while (state_o != 2'd1 && n < 100);
        chk("restart_latency", n, 12);
        chk("restart_game_rst", int'(game_rst_o), 1);
        chk("restart_new_food", int'(new_food_flag_o), 1);
        step();
        chk("play_state", int'(state_o), 2);
        chk("play_run", int'(run_o), 1);
        chk("play_game_rst_low", int'(game_rst_o), 0);
        chk("play_new_food_low", int'(new_food_flag_o), 0);

        // Frame period versus length, including the floor.
        for (int i = 0; i < 4; i++) begin
            snek_len = LW'(lens[i]);
            wait_tick("frame_sync");
            n = 0;
            do begin step(); n++; end while (frame_tick_o !== 1'b1 && n < 400);
            chk($sformatf("frame_period_len%0d", lens[i]), n, pers[i]);
        end

        // Steering.
        snek_len = LW'(9);
        buttons = 4'b0100; wait_tick("dir_up");    chk("dir_up", int'(dir_o), 2);
        buttons = 4'b0001; wait_tick("dir_right"); chk("dir_right", int'(dir_o), 1);
        buttons = 4'b0010; step(); chk("dir_left_held_pre", int'(dir_o), 1);
        wait_tick("dir_left_rev"); chk("dir_reverse_dropped", int'(dir_o), 1);
        buttons = 4'b1000; step(); step(); buttons = 4'd0;
        wait_tick("dir_down_rel"); chk("dir_down_released", int'(dir_o), 3);
        buttons = 4'b0001; wait_tick("dir_right2"); chk("dir_right2", int'(dir_o), 1);
        buttons = 4'b0100;
        repeat (5) step();
        chk("dir_const_between_ticks", int'(dir_o), 1);
        wait_tick("dir_up2"); chk("dir_up_at_tick", int'(dir_o), 2);
        buttons = 4'd0;

        // Single food hit held for 50 cycles.
        food_h = 6'd5; food_v = 6'd5;
        grows = 0; nfs = 0;
        repeat (50) begin step(); grows += int'(grow_flag_o); nfs += int'(new_food_flag_o); end
        chk("hit_grow_count", grows, 1);
        chk("hit_new_food_count", nfs, 1);
        chk("hit_score", int'(score_o), 1);

        // Saturation.
        repeat (260) toggle_hit();
        chk("score_saturated", int'(score_o), 255);
        toggle_hit();
        chk("sat_grow_pulse", int'(grow_flag_o), 1);
        chk("sat_score_hold", int'(score_o), 255);

        // Death coinciding with a fresh match.
        food_h = 6'd10; food_v = 6'd10; step();
        food_h = 6'd5;  food_v = 6'd5;  dead = 1'b1; step();
        dead = 1'b0; food_h = 6'd10; food_v = 6'd10;
        chk("dead_state", int'(state_o), 3);
        chk("dead_no_grow", int'(grow_flag_o), 0);
        chk("dead_score_held", int'(score_o), 255);
        chk("dead_run_low", int'(run_o), 0);
        n = 0;
        do begin step(); n++; end while (state_o != 2'd1 && n < 50);
        chk("dying_to_restart", int'(state_o), 1);
        chk("restart_score_clear", int'(score_o), 0);
        step();
        chk("replay_state", int'(state_o), 2);

        // Out-of-range food row.
        food_v = 6'd24; nfs = 0;
        repeat (6) begin step(); nfs += int'(new_food_flag_o); end
        chk("invalid_food_held", nfs, 6);
        food_v = 6'd23; step();
        chk("valid_food_released", int'(new_food_flag_o), 0);

        // Mid-game reset with score 4 and heading up.
        buttons = 4'b0100; wait_tick("pre_rst_dir"); buttons = 4'd0;
        repeat (4) toggle_hit();
        chk("pre_rst_score", int'(score_o), 4);
        chk("pre_rst_dir", int'(dir_o), 2);
        food_h = 6'd10; food_v = 6'd10;
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_state", int'(state_o), 0);
        chk("rst_score", int'(score_o), 0);
        chk("rst_dir", int'(dir_o), 0);
        chk("rst_no_game_rst", int'(game_rst_o), 0);

        buttons = 4'b0001; step(); buttons = 4'd0;
`ifdef SNEK_SPLASH_SKIP_EN
        chk("splash_skip", int'(state_o), 1);
`else
        chk("splash_no_skip", int'(state_o), 0);
`endif

        // Randomised play checked by the scoreboard.
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 599) == 0);
            dead    = ($urandom_range(0, 99) == 0);
            buttons = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
            if ($urandom_range(0, 3) == 0) begin
                head_h = 6'($urandom_range(0, 3));
                head_v = 6'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 3) == 0) begin
                food_h = ($urandom_range(0, 19) == 0) ? 6'($urandom_range(30, 40)) : 6'($urandom_range(0, 3));
                food_v = ($urandom_range(0, 19) == 0) ? 6'($urandom_range(22, 30)) : 6'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 49) == 0) snek_len = LW'($urandom_range(0, 255));
            step();
        end
        rst = 1'b0; dead = 1'b0; buttons = 4'd0;
        repeat (2) step();
        @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/snek_game_ctrl.md
Name: snek_game_ctrl

Overview:
- Parametrised game-control core for the snek family. Replaces the ad-hoc control logic in the top level.
- Owns four functions: the splash/play/death state machine, direction capture with reversal rejection, a frame-tick generator whose period is floored, and food-hit/score bookkeeping.
- Sits between the button inputs, snekgen and foodgen. Drives their grow/new-food/reset/run controls. The VGA path remains outside this block.

Parameters:
- GRID_W, 32, playfield width in cells; valid food_h range is 0..GRID_W-1
- GRID_H, 24, playfield height in cells; valid food_v range is 0..GRID_H-1
- COORD_W, 6, width of head/food coordinate ports
- LEN_W, 8, width of snek_len and score
- TICK_BASE, 3125000, frame period in clk cycles at length 0
- TICK_STEP, 200000, period reduction per body segment
- TICK_MIN, 625000, floor on frame period
- MS_CYCLES, 12500, clk cycles per millisecond tick
- SPLASH_MS, 10000, splash duration in ms
- DEAD_MS, 2000, death pause in ms

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- buttons  in  4  [0]=right [1]=left [2]=up [3]=down, level-sensitive
- head_h  in  COORD_W  snake head column
- head_v  in  COORD_W  snake head row
- food_h  in  COORD_W  food column
- food_v  in  COORD_W  food row
- snek_len  in  LEN_W  current body length
- dead  in  1  collision indication from snekgen
- dir  out  2  0=left 1=right 2=up 3=down
- frame_tick  out  1  one-cycle pulse per movement step
- grow_flag  out  1  one-cycle pulse on food hit
- new_food_flag  out  1  request new food placement
- game_rst  out  1  one-cycle pulse that resets snekgen/foodgen
- run  out  1  high only in PLAY
- state  out  2  0=SPLASH 1=RESTART 2=PLAY 3=DYING
- score  out  LEN_W  food eaten this game, saturating

Behaviour:
- Reset values:
  - state=SPLASH, dir=0
  - all pulse outputs=0, run=0, score=0
  - ms prescaler, ms counter and frame counter=0
- Ms prescaler: counts 0..MS_CYCLES-1 and pulses ms_tick on wrap. It runs in every state.
- SPLASH:
  - Counts ms_ticks.
  - When the count reaches SPLASH_MS, go to RESTART on the next cycle and clear the count.
- RESTART (exactly 1 cycle):
  - game_rst=1, new_food_flag=1, score cleared, dir=0, frame counter cleared.
  - Next state is PLAY.
- PLAY:
  - run=1; frame counter runs.
  - If dead=1: go to DYING, clear the ms count. No frame_tick is issued in the same cycle.
- DYING:
  - run=0; frame_tick suppressed; score held.
  - After DEAD_MS ms_ticks, go to RESTART. SPLASH is not revisited.
- Frame period:
  - P = TICK_BASE - TICK_STEP*snek_len, computed at 32 bits or wider.
  - If the product is ≥ TICK_BASE-TICK_MIN, P=TICK_MIN. There is no underflow at any snek_len.
  - P is sampled when the counter reloads. The counter counts 0..P-1 and frame_tick pulses on the cycle it wraps.
- Direction:
  - Button priority is left > right > up > down. The candidate direction is latched into pending_dir every cycle a button is held.
  - pending_dir is committed to dir on frame_tick, unless it is the exact reverse of the current dir (left↔right, up↔down). A reverse is dropped and dir is kept.
  - With no buttons held, pending_dir holds its value.
  - dir is constant between frame_ticks.
- Food hit:
  - Condition is match = (head_h==food_h && head_v==food_v), compared at COORD_W width.
  - grow_flag and new_food_flag pulse for 1 cycle on the rising edge of match while in PLAY.
  - A sustained match does not retrigger. Matches outside PLAY are ignored.
  - score increments on each hit and saturates at 2^LEN_W-1.
- Invalid food: when food_h≥GRID_W or food_v≥GRID_H, new_food_flag is held high in every state until valid. This takes precedence; it ORs with the hit pulse.
- Simultaneous dead and match in the same PLAY cycle: dead wins. No grow_flag and no score change.
- rst asserted mid-game forces the reset values on the next edge. game_rst is not pulsed by rst.

Optional Feature:
- Macro SNEK_SPLASH_SKIP_EN.
- Defined: any buttons bit high in SPLASH moves to RESTART on the next cycle, regardless of the ms count. The press is not latched as a direction.
- Undefined: buttons are ignored in SPLASH, and only the SPLASH_MS timeout exits.

Test Plan:
- Splash and restart timing (MS_CYCLES=4, SPLASH_MS=3, rst 1 cycle): RESTART is entered exactly 12 cycles after reset release. game_rst and new_food_flag are high for 1 cycle, then state=2 and run=1.
- Frame floor (TICK_BASE=100, TICK_STEP=10, TICK_MIN=30, in PLAY):
  - snek_len=0 gives frame_tick every 100 cycles.
  - snek_len=5 gives every 50.
  - snek_len=9 and snek_len=200 both give every 30.
- Direction commit (dir=1/right, frame ticks in PLAY):
  - Hold left: dir stays 1 across the tick.
  - Hold up: dir=2 only after the next frame_tick.
  - Press down then release before the tick: dir=3 at the tick.
- Food hit (head=(5,5), food moved to (5,5) and held 50 cycles): grow_flag=1 and new_food_flag=1 for exactly 1 cycle, score 0→1. Repeat with score=255: grow pulses but score stays 255.
- Death and priority:
  - dead=1 and match in the same cycle: state=3, no grow_flag, score unchanged.
  - After DEAD_MS ms_ticks: RESTART, score=0, then PLAY.
  - food_v=24: new_food_flag held high until food_v≤23.
- Mid-game rst: assert rst in PLAY with score=4, dir=2: next cycle state=0, score=0, dir=0, game_rst=0. With SNEK_SPLASH_SKIP_EN, buttons=4'b0001 in SPLASH gives RESTART next cycle.
